// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - requester and SRAM-controller bundle for sram_arbiter
interface sram_arbiter_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ-1:0]    lock;
    logic [NUM_REQ-1:0]    we_n;
    logic [NUM_REQ*18-1:0] addr;
    logic [NUM_REQ*16-1:0] wdata;
    logic [NUM_REQ-1:0]    gnt;
    logic [NUM_REQ-1:0]    rvalid;
    logic [15:0]           rdata;
    logic                  SRAM_ready;
    logic [17:0]           SRAM_address;
    logic [15:0]           SRAM_write_data;
    logic                  SRAM_we_n;
    logic [15:0]           SRAM_read_data;

    modport master (
        output req, lock, we_n, addr, wdata, SRAM_ready, SRAM_read_data,
        input  gnt, rvalid, rdata, SRAM_address, SRAM_write_data, SRAM_we_n
    );

    modport slave (
        input  req, lock, we_n, addr, wdata, SRAM_ready, SRAM_read_data,
        output gnt, rvalid, rdata, SRAM_address, SRAM_write_data, SRAM_we_n
    );
endinterface

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - round-robin arbiter with burst lock sharing one SRAM controller port
module sram_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int READ_LATENCY = 2
) (
    input  logic           Clock_50,
    input  logic           Reset,
    sram_arbiter_if.slave  bus
);
    localparam int IW = (NUM_REQ > 2) ? 2 : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t               state;
    logic [IW-1:0]        ptr;
    logic [IW-1:0]        owner;
    logic [IW-1:0]        winner;
    logic                 found;
    logic [IW-1:0]        gidx;
    logic [NUM_REQ-1:0]   gnt_c;
    logic                 accept;
    logic [READ_LATENCY:0] tag_v;
    logic [IW-1:0]        tag_id [READ_LATENCY+1];

    // Scan downward so the requester closest to ptr is assigned last and wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req[IW'((int'(ptr) + k) % NUM_REQ)]) begin
                winner = IW'((int'(ptr) + k) % NUM_REQ);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        gnt_c = '0;
        if (bus.SRAM_ready) begin
            if (state == LOCKED) begin
                if (bus.req[owner]) gnt_c[owner] = 1'b1;
            end else if (found) begin
                gnt_c[winner] = 1'b1;
            end
        end
    end

    assign gidx    = (state == LOCKED) ? owner : winner;
    assign accept  = |gnt_c;
    assign bus.gnt = gnt_c;

    always_ff @(posedge Clock_50 or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            ptr   <= '0;
            owner <= '0;
        end else if (bus.SRAM_ready) begin
            if (state == IDLE) begin
                if (found) begin
                    ptr <= (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
                    if (bus.lock[winner]) begin
                        state <= LOCKED;
                        owner <= winner;
                    end
                end
            end else if (!(bus.req[owner] && bus.lock[owner])) begin
                state <= IDLE;
            end
        end
    end

    // Tag pipeline runs every cycle so read data lines up with the fixed controller latency.
    always_ff @(posedge Clock_50 or posedge Reset) begin
        if (Reset) begin
            bus.SRAM_address    <= '0;
            bus.SRAM_write_data <= '0;
            bus.SRAM_we_n       <= 1'b1;
            bus.rvalid          <= '0;
            bus.rdata           <= '0;
            tag_v               <= '0;
            for (int k = 0; k <= READ_LATENCY; k++) tag_id[k] <= '0;
        end else begin
            bus.SRAM_we_n <= 1'b1;
            if (accept) begin
                bus.SRAM_address    <= bus.addr[18*gidx +: 18];
                bus.SRAM_write_data <= bus.wdata[16*gidx +: 16];
                bus.SRAM_we_n       <= bus.we_n[gidx];
            end
            tag_v     <= {tag_v[READ_LATENCY-1:0], accept & bus.we_n[gidx]};
            tag_id[0] <= gidx;
            for (int k = 1; k <= READ_LATENCY; k++) tag_id[k] <= tag_id[k-1];
            bus.rvalid <= tag_v[READ_LATENCY] ? (NUM_REQ'(1) << tag_id[READ_LATENCY]) : '0;
            if (tag_v[READ_LATENCY]) bus.rdata <= bus.SRAM_read_data;
        end
    end
endmodule
